fifo_read_ctrl: RTL and testbench
=================================

Name: fifo_read_ctrl

Overview:
- Read-side controller for fifo_memory. Drains it into a downstream valid/ready stream.
- Issues fifo_read_enable only when the FIFO is non-empty and there is room to land the data.
- Absorbs the FIFO's 1-cycle synchronous read latency with a 2-entry output skid buffer.
- Lets consumers apply back-pressure without losing or duplicating words, and counts delivered words.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and m_data.
- COUNT_WIDTH, 16, width of drain_count.

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rstn  input  1  asynchronous, active-low reset.
- enable  input  1  run request; high = drain FIFO, low = stop issuing reads.
- fifo_empty  input  1  empty flag from fifo_memory.
- fifo_read_data  input  DATA_WIDTH  read data from fifo_memory; valid the cycle after fifo_read_enable.
- fifo_read_enable  output  1  read strobe to fifo_memory.
- m_valid  output  1  output word available.
- m_data  output  DATA_WIDTH  output word.
- m_ready  input  1  consumer accepts m_data when m_valid && m_ready.
- busy  output  1  high in ACTIVE or DRAINING.
- drain_count  output  COUNT_WIDTH  number of accepted output transfers.

Behaviour:
- Reset (rstn low, asynchronous):
  - state=IDLE; buffer count=0; inflight=0; drain_count=0.
  - fifo_read_enable=0, m_valid=0, m_data=0, busy=0.
- Definitions:
  - pop = m_valid && m_ready.
  - inflight = registered copy of the previous cycle's fifo_read_enable.
  - occ = buf_count + inflight - pop (range 0..2).
- fifo_read_enable is combinational:
  - fifo_read_enable = (state==ACTIVE) && !fifo_empty && (occ < 2).
  - It depends combinationally on m_ready and fifo_empty.
  - Never assert it while fifo_empty=1.
- Capture: when inflight=1, write fifo_read_data into the buffer tail on that edge. Capture is unconditional; the occ rule guarantees space.
- Output:
  - m_valid = (buf_count != 0); m_data = buffer head.
  - Head must hold stable while m_valid && !m_ready.
  - Pop and capture in the same cycle are legal; buf_count changes by capture minus pop.
- Ordering: strict FIFO order, no drop, no duplication.
- Throughput: with m_ready held high and the FIFO non-empty, one read and one transfer per cycle. First m_valid appears 2 cycles after the first fifo_read_enable edge: 1 cycle read latency plus 1 cycle capture.
- drain_count: +1 on each pop; wraps modulo 2^COUNT_WIDTH.
- State machine (states IDLE, ACTIVE, DRAINING):
  - IDLE -> ACTIVE when enable=1.
  - ACTIVE -> DRAINING when enable=0.
  - DRAINING: no new reads issued. The in-flight word is still captured and buffered words are still output.
    - -> IDLE when buf_count=0, inflight=0 and no capture is pending.
    - -> ACTIVE if enable rises again before that.
  - busy = (state != IDLE).
- Boundary cases:
  - fifo_empty rising while a read is in flight: that word is still captured.
  - enable toggling every cycle: no word lost.
  - Reset mid-transfer: in-flight and buffered words are discarded. The outputs listed under Reset take their reset values immediately, asynchronously.

Optional Feature:
- Macro FIFO_READ_CTRL_PARITY_EN.
- Defined:
  - Extra output port m_parity (1 bit) = XOR reduction of m_data, i.e. even parity.
  - Stored alongside each buffer entry, computed at capture, stable with m_data.
  - Resets to 0.
- Undefined: port absent, no parity logic. All other behaviour identical.

Test Plan:
- Reset: hold rstn=0 with enable=1, fifo_empty=0 -> fifo_read_enable=0, m_valid=0, busy=0, drain_count=0. Release -> first read strobe within 1 cycle.
- Streaming: FIFO preloaded 0x12,0x34,0x56 (empty after 3 reads), m_ready=1, enable=1 -> fifo_read_enable high 3 consecutive cycles; m_data 0x12,0x34,0x56 on consecutive cycles starting 2 cycles after the first strobe; drain_count=3; empty never read.
- Back-pressure: FIFO holds 0x01..0x04, m_ready=0 -> exactly 2 strobes issued, m_data=0x01 held stable. Raise m_ready -> 0x01..0x04 delivered in order, total 4 strobes, drain_count=4.
- Stop mid-stream: 6 words queued, m_ready=1; drop enable after the 2nd strobe -> state DRAINING, no 3rd strobe. In-flight and buffered words delivered (drain_count=2), then busy falls. Re-raise enable -> remaining 4 words delivered, drain_count=6.
- Empty FIFO: fifo_empty=1 for 20 cycles with enable=1, m_ready=1 -> fifo_read_enable never asserted, m_valid=0, busy=1.
- Async reset mid-operation: assert rstn=0 between clock edges with 2 words buffered -> m_valid drops immediately, drain_count=0. With FIFO_READ_CTRL_PARITY_EN, a captured word 0x07 gives m_parity=1 and 0x03 gives m_parity=0.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// fifo_read_ctrl: drains fifo_memory (1-cycle synchronous read) into a
// valid/ready stream through a 2-entry skid buffer and counts delivered words.
// Optional even-parity sideband: define FIFO_READ_CTRL_PARITY_EN to add the
// m_parity output.
module fifo_read_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   enable,
    input  logic                   fifo_empty,
    input  logic [DATA_WIDTH-1:0]  fifo_read_data,
    output logic                   fifo_read_enable,
    output logic                   m_valid,
    output logic [DATA_WIDTH-1:0]  m_data,
    input  logic                   m_ready,
    output logic                   busy,
    output logic [COUNT_WIDTH-1:0] drain_count
`ifdef FIFO_READ_CTRL_PARITY_EN
    ,
    output logic                   m_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACTIVE   = 2'd1,
        DRAINING = 2'd2
    } state_e;

    state_e                          state_q, state_d;
    logic                            busy_q, busy_d;
    logic [1:0]                      buf_count_q, buf_count_d;
    logic                            inflight_q, inflight_d;
    logic [1:0][DATA_WIDTH-1:0]      buf_q, buf_d;
    logic [COUNT_WIDTH-1:0]          drain_count_q, drain_count_d;
`ifdef FIFO_READ_CTRL_PARITY_EN
    logic [1:0]                      par_q, par_d;
`endif

    logic       pop;
    logic [2:0] occ;
    logic       wr_idx;

    assign m_valid     = (buf_count_q != 2'd0);
    assign m_data      = buf_q[0];
    assign busy        = busy_q;
    assign drain_count = drain_count_q;
`ifdef FIFO_READ_CTRL_PARITY_EN
    assign m_parity    = par_q[0];
`endif

    // Read issue: words already held plus the one in flight, minus the one
    // leaving this cycle, must leave a free slot for the word being requested.
    always_comb begin
        pop              = m_valid && m_ready;
        occ              = {1'b0, buf_count_q} + {2'b00, inflight_q} - {2'b00, pop};
        fifo_read_enable = (state_q == ACTIVE) && !fifo_empty && (occ < 3'd2);
        inflight_d       = fifo_read_enable;
    end

    // Skid buffer: entry 0 is the head; a pop shifts entry 1 down, and the
    // returning read word lands at slot (count - pop). count-pop is only 0 or 1
    // whenever a capture happens, so its low bit is count[0] ^ pop.
    always_comb begin
        buf_d         = buf_q;
`ifdef FIFO_READ_CTRL_PARITY_EN
        par_d         = par_q;
`endif
        wr_idx        = buf_count_q[0] ^ pop;
        if (pop) begin
            buf_d[0] = buf_q[1];
`ifdef FIFO_READ_CTRL_PARITY_EN
            par_d[0] = par_q[1];
`endif
        end
        if (inflight_q) begin
            buf_d[wr_idx] = fifo_read_data;
`ifdef FIFO_READ_CTRL_PARITY_EN
            par_d[wr_idx] = ^fifo_read_data;
`endif
        end
        buf_count_d   = buf_count_q + {1'b0, inflight_q} - {1'b0, pop};
        drain_count_d = drain_count_q + COUNT_WIDTH'(pop);
    end

    // Run-state sequencing; DRAINING waits for the buffer and any read in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (enable) state_d = ACTIVE;
            ACTIVE:   if (!enable) state_d = DRAINING;
            DRAINING: begin
                if (enable)
                    state_d = ACTIVE;
                else if ((buf_count_q == 2'd0) && !inflight_q)
                    state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // All controller state; reset discards buffered and in-flight words.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            busy_q        <= 1'b0;
            buf_count_q   <= 2'd0;
            inflight_q    <= 1'b0;
            buf_q         <= '0;
            drain_count_q <= '0;
`ifdef FIFO_READ_CTRL_PARITY_EN
            par_q         <= 2'b00;
`endif
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            buf_count_q   <= buf_count_d;
            inflight_q    <= inflight_d;
            buf_q         <= buf_d;
            drain_count_q <= drain_count_d;
`ifdef FIFO_READ_CTRL_PARITY_EN
            par_q         <= par_d;
`endif
        end
    end

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// Bench for fifo_read_ctrl: a behavioural fifo_memory model feeds the DUT;
// a scoreboard checks order, count, stability and read-while-empty.
module tb_fifo_read_ctrl;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        enable = 1'b0;
    logic        fifo_empty;
    logic [7:0]  fifo_read_data = 8'h00;
    logic        fifo_read_enable;
    logic        m_valid;
    logic [7:0]  m_data;
    logic        m_ready = 1'b0;
    logic        busy;
    logic [15:0] drain_count;
`ifdef FIFO_READ_CTRL_PARITY_EN
    logic        m_parity;
`endif

    fifo_read_ctrl #(.DATA_WIDTH(8), .COUNT_WIDTH(16)) dut (
        .clk(clk), .rstn(rstn), .enable(enable), .fifo_empty(fifo_empty),
        .fifo_read_data(fifo_read_data), .fifo_read_enable(fifo_read_enable),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready), .busy(busy),
        .drain_count(drain_count)
`ifdef FIFO_READ_CTRL_PARITY_EN
        , .m_parity(m_parity)
`endif
    );

    always #5 clk = ~clk;

    // fifo_memory model: word store plus read pointer, 1-cycle read latency
    logic [7:0] mem [0:1023];
    int         wr_ptr = 0;
    int         rd_ptr = 0;
    logic       flush = 1'b0;
    logic       force_empty = 1'b0;
    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (flush)
            rd_ptr <= wr_ptr;
        else if (fifo_read_enable && !fifo_empty) begin
            fifo_read_data <= mem[rd_ptr];
            rd_ptr         <= rd_ptr + 1;
        end
    end

    int tests = 0;
    int fails = 0;
    int exp_idx = 0;
    int acc_cnt = 0;
    int strobe_cnt = 0;
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] d);
        if (wr_ptr < 1024) begin
            mem[wr_ptr] = d;
            wr_ptr++;
        end
    endtask

    // Scoreboard step, called at the negedge before each active edge.
    task automatic mon();
        if (rstn) begin
            if (fifo_read_enable) strobe_cnt++;
            chk("read_while_empty", 32'(fifo_read_enable && fifo_empty), 0);
            chk("drain_count", 32'(drain_count), 32'(acc_cnt[15:0]));
            if (stall_prev) chk("hold_stable", {m_valid, m_data}, {1'b1, stall_data});
`ifdef FIFO_READ_CTRL_PARITY_EN
            if (m_valid) chk("parity", 32'(m_parity), 32'(^m_data));
`endif
            if (m_valid && m_ready) begin
                chk("word_exists", 32'(exp_idx < wr_ptr), 1);
                if (exp_idx < wr_ptr) chk("order", 32'(m_data), 32'(mem[exp_idx]));
                exp_idx++;
                acc_cnt++;
            end
            stall_prev = m_valid && !m_ready;
            stall_data = m_data;
        end
    endtask

    task automatic run(input int n);
        repeat (n) begin
            @(negedge clk);
            mon();
            @(posedge clk);
            #1;
        end
    endtask

    // Enter reset, drop leftover FIFO contents, resync the scoreboard.
    task automatic do_reset();
        rstn = 1'b0;
        flush = 1'b1;
        force_empty = 1'b0;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        exp_idx = rd_ptr;
        acc_cnt = 0;
        strobe_cnt = 0;
        stall_prev = 1'b0;
    endtask

    task automatic release_reset();
        @(posedge clk); #1;
        rstn = 1'b1;
    endtask

    typedef struct {
        logic        en;
        logic        rdy;
        logic        fre;
        logic        mv;
        logic [7:0]  data;
        logic        bsy;
        logic [15:0] dc;
    } vec_t;

    vec_t vt [7];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        // Streaming 0x12,0x34,0x56 with m_ready=1, rows sampled per cycle after reset release
        vt[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 16'd0};
        vt[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
        vt[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 16'd0};
        vt[3] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h12, 1'b1, 16'd0};
        vt[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h34, 1'b1, 16'd1};
        vt[5] = '{1'b1, 1'b1, 1'b0, 1'b1, 8'h56, 1'b1, 16'd2};
        vt[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 16'd3};

        // Reset held with enable=1 and data available
        do_reset();
        push(8'h12); push(8'h34); push(8'h56);
        enable = 1'b1; m_ready = 1'b1;
        @(negedge clk);
        chk("rst_fre", 32'(fifo_read_enable), 0);
        chk("rst_mvalid", 32'(m_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_dcount", 32'(drain_count), 0);
        release_reset();

        // Streaming table
        for (int i = 0; i < 7; i++) begin
            enable = vt[i].en; m_ready = vt[i].rdy;
            @(negedge clk);
            chk($sformatf("stream_fre[%0d]", i), 32'(fifo_read_enable), 32'(vt[i].fre));
            chk($sformatf("stream_mv[%0d]", i), 32'(m_valid), 32'(vt[i].mv));
            if (vt[i].mv) chk($sformatf("stream_data[%0d]", i), 32'(m_data), 32'(vt[i].data));
            chk($sformatf("stream_busy[%0d]", i), 32'(busy), 32'(vt[i].bsy));
            chk($sformatf("stream_dc[%0d]", i), 32'(drain_count), 32'(vt[i].dc));
            mon();
            @(posedge clk); #1;
        end
        run(3);
        chk("stream_strobes", 32'(strobe_cnt), 3);

        // Back-pressure: only two reads may be outstanding, head held
        do_reset();
        push(8'h01); push(8'h02); push(8'h03); push(8'h04);
        enable = 1'b1; m_ready = 1'b0;
        release_reset();
        run(8);
        chk("bp_strobes", 32'(strobe_cnt), 2);
        chk("bp_head", {m_valid, m_data}, {1'b1, 8'h01});
        m_ready = 1'b1;
        k = 0;
        while (acc_cnt < 4 && k < 40) begin run(1); k++; end
        run(3);
        chk("bp_total_strobes", 32'(strobe_cnt), 4);
        chk("bp_dcount", 32'(drain_count), 4);

        // Stop mid-stream, drain, resume
        do_reset();
        for (int i = 0; i < 6; i++) push(8'(8'hA0 + i));
        enable = 1'b1; m_ready = 1'b1;
        release_reset();
        k = 0;
        while (strobe_cnt < 1 && k < 10) begin run(1); k++; end
        enable = 1'b0;
        run(2);
        chk("stop_busy_draining", 32'(busy), 1);
        k = 0;
        while (busy && k < 20) begin run(1); k++; end
        chk("stop_busy_fell", 32'(busy), 0);
        chk("stop_strobes", 32'(strobe_cnt), 2);
        chk("stop_dcount", 32'(drain_count), 2);
        enable = 1'b1;
        k = 0;
        while (acc_cnt < 6 && k < 40) begin run(1); k++; end
        run(2);
        chk("resume_dcount", 32'(drain_count), 6);
        chk("resume_strobes", 32'(strobe_cnt), 6);

        // Empty FIFO: never strobe
        do_reset();
        enable = 1'b1; m_ready = 1'b1;
        release_reset();
        run(20);
        chk("empty_strobes", 32'(strobe_cnt), 0);
        chk("empty_mvalid", 32'(m_valid), 0);
        chk("empty_busy", 32'(busy), 1);

        // Async reset with two words buffered
        do_reset();
        for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
        enable = 1'b1; m_ready = 1'b1;
        release_reset();
        run(5);
        m_ready = 1'b0;
        run(4);
        chk("arst_pre_mvalid", 32'(m_valid), 1);
        chk("arst_pre_dcount_nz", 32'(drain_count != 0), 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_mvalid", 32'(m_valid), 0);
        chk("arst_dcount", 32'(drain_count), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_fre", 32'(fifo_read_enable), 0);
`ifdef FIFO_READ_CTRL_PARITY_EN
        chk("arst_parity", 32'(m_parity), 0);
`endif
        // Restart after reset, parity of 0x07 and 0x03
        do_reset();
        push(8'h07); push(8'h03);
        enable = 1'b1; m_ready = 1'b0;
        release_reset();
        run(6);
        chk("p07_data", {m_valid, m_data}, {1'b1, 8'h07});
`ifdef FIFO_READ_CTRL_PARITY_EN
        chk("p07_parity", 32'(m_parity), 1);
`endif
        m_ready = 1'b1;
        run(1);
        m_ready = 1'b0;
        chk("p03_data", {m_valid, m_data}, {1'b1, 8'h03});
`ifdef FIFO_READ_CTRL_PARITY_EN
        chk("p03_parity", 32'(m_parity), 0);
`endif
        m_ready = 1'b1;
        run(2);

        // Randomized traffic, then enable toggling every cycle
        do_reset();
        release_reset();
        for (int c = 0; c < 500; c++) begin
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            enable      = ($urandom_range(0, 9) != 0);
            m_ready     = ($urandom_range(0, 9) < 6);
            force_empty = ($urandom_range(0, 9) == 0);
            run(1);
        end
        for (int c = 0; c < 80; c++) begin
            if ($urandom_range(0, 1) == 0) push(8'($urandom));
            enable      = ~enable;
            m_ready     = ($urandom_range(0, 3) != 0);
            force_empty = 1'b0;
            run(1);
        end
        enable = 1'b1; m_ready = 1'b1; force_empty = 1'b0;
        k = 0;
        while ((exp_idx < wr_ptr || m_valid) && k < 600) begin run(1); k++; end
        chk("rand_all_delivered", 32'(exp_idx), 32'(wr_ptr));
        chk("rand_dcount", 32'(drain_count), 32'(acc_cnt[15:0]));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
